// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable almost flags, fill count,
// optional first-word-fall-through read, and error pulse plus sticky flags.
module sync_fifo_prog #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int PTR_WIDTH = 4,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = 14,
  parameter int AE_THRESH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [WIDTH-1:0]     wdata,
  output logic                 full,
  output logic                 almost_full,
  input  logic                 rd_en,
  output logic [WIDTH-1:0]     rdata,
  output logic                 rvalid,
  output logic                 empty,
  output logic                 almost_empty,
  output logic [PTR_WIDTH:0]   count,
  output logic                 error,
  output logic                 ovf_sticky,
  output logic                 unf_sticky,
  input  logic                 clr_err
);
  localparam logic [PTR_WIDTH:0] DEPTH_C = (PTR_WIDTH+1)'(DEPTH);
  localparam logic [PTR_WIDTH:0] AF_C    = (PTR_WIDTH+1)'(AF_THRESH);
  localparam logic [PTR_WIDTH:0] AE_C    = (PTR_WIDTH+1)'(AE_THRESH);
  logic [WIDTH-1:0]     mem [DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_WIDTH:0]   count_q, count_d;
  logic                 error_q, error_d, ovf_q, ovf_d, unf_q, unf_d;
  logic                 wr_acc, rd_acc, overflow, underflow;
  always_comb begin
    full         = count_q == DEPTH_C;
    empty        = count_q == '0;
    almost_full  = count_q >= AF_C;
    almost_empty = count_q <= AE_C;
    wr_acc       = wr_en & ~full;
    rd_acc       = rd_en & ~empty;
    overflow     = wr_en & full;
    underflow    = rd_en & empty;
    wr_ptr_d     = wr_ptr_q + PTR_WIDTH'(wr_acc);
    rd_ptr_d     = rd_ptr_q + PTR_WIDTH'(rd_acc);
    count_d      = count_q + (PTR_WIDTH+1)'(wr_acc) - (PTR_WIDTH+1)'(rd_acc);
    error_d      = overflow | underflow;
    // a new event outranks a coincident clear
    ovf_d        = overflow | (ovf_q & ~clr_err);
    unf_d        = underflow | (unf_q & ~clr_err);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      error_q  <= error_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  always_ff @(posedge clk)
    if (wr_acc && !rst) mem[wr_ptr_q] <= wdata;
  assign count      = count_q;
  assign error      = error_q;
  assign ovf_sticky = ovf_q;
  assign unf_sticky = unf_q;
  if (FWFT != 0) begin : g_fwft
    assign rdata  = empty ? '0 : mem[rd_ptr_q];
    assign rvalid = ~empty;
  end else begin : g_std
    logic [WIDTH-1:0] rdata_q;
    logic             rvalid_q;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_acc;
        if (rd_acc) rdata_q <= mem[rd_ptr_q];
      end
    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;
  end
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: directed checks of a standard-read and a fall-through FIFO
// driven by the same stimulus.
module tb_sync_fifo_prog;
  logic       clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
  logic [7:0] wdata = '0;
  logic       full0, af0, empty0, ae0, rvalid0, error0, ovf0, unf0;
  logic       full1, af1, empty1, ae1, rvalid1, error1, ovf1, unf1;
  logic [7:0] rdata0, rdata1;
  logic [4:0] count0, count1;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  sync_fifo_prog #(.FWFT(0)) u_std (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .full(full0),
    .almost_full(af0), .rd_en(rd_en), .rdata(rdata0), .rvalid(rvalid0),
    .empty(empty0), .almost_empty(ae0), .count(count0), .error(error0),
    .ovf_sticky(ovf0), .unf_sticky(unf0), .clr_err(clr_err));

  sync_fifo_prog #(.FWFT(1)) u_fwft (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wdata(wdata), .full(full1),
    .almost_full(af1), .rd_en(rd_en), .rdata(rdata1), .rvalid(rvalid1),
    .empty(empty1), .almost_empty(ae1), .count(count1), .error(error1),
    .ovf_sticky(ovf1), .unf_sticky(unf1), .clr_err(clr_err));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    chk("rst_count", count0, 0);
    chk("rst_empty", empty0, 1);
    chk("rst_ae", ae0, 1);
    chk("rst_full", full0, 0);
    chk("rst_af", af0, 0);
    chk("rst_rvalid", rvalid0, 0);
    chk("rst_rdata", rdata0, 0);
    chk("rst_error", error0, 0);
    chk("rst_ovf", ovf0, 0);
    chk("rst_unf", unf0, 0);
    chk("rst_fw_rvalid", rvalid1, 0);
    rst = 1'b0;
    rd_en = 1'b1;
    tick();
    chk("unf_error", error0, 1);
    chk("unf_sticky", unf0, 1);
    chk("unf_count", count0, 0);
    chk("unf_rvalid", rvalid0, 0);
    clr_err = 1'b1;
    tick();
    chk("unf_clr_coincide", unf0, 1);
    chk("unf_error2", error0, 1);
    rd_en = 1'b0;
    clr_err = 1'b0;
    tick();
    chk("unf_error_drop", error0, 0);
    chk("unf_sticky_hold", unf0, 1);
    clr_err = 1'b1;
    tick();
    chk("unf_cleared", unf0, 0);
    clr_err = 1'b0;
    wr_en = 1'b1;
    wdata = 8'h5A;
    tick();
    chk("fw_rvalid", rvalid1, 1);
    chk("fw_rdata", rdata1, 8'h5A);
    chk("fw_empty", empty1, 0);
    chk("std_no_rvalid", rvalid0, 0);
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    chk("fw_pop_empty", empty1, 1);
    chk("fw_pop_rvalid", rvalid1, 0);
    chk("std_rvalid_5a", rvalid0, 1);
    chk("std_rdata_5a", rdata0, 8'h5A);
    rd_en = 1'b0;
    tick();
    chk("std_rvalid_pulse", rvalid0, 0);
    chk("std_rdata_hold", rdata0, 8'h5A);
    wr_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wdata = 8'(i);
      tick();
      chk($sformatf("fill_count%0d", i), count0, i);
      chk($sformatf("fill_af%0d", i), af0, i >= 14);
      chk($sformatf("fill_full%0d", i), full0, i == 16);
    end
    chk("fw_head", rdata1, 8'h01);
    wdata = 8'hAA;
    tick();
    chk("ovf_error", error0, 1);
    chk("ovf_sticky", ovf0, 1);
    chk("ovf_count", count0, 16);
    wr_en = 1'b0;
    tick();
    chk("ovf_error_drop", error0, 0);
    chk("ovf_sticky_hold", ovf0, 1);
    clr_err = 1'b1;
    tick();
    chk("ovf_cleared", ovf0, 0);
    clr_err = 1'b0;
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk($sformatf("drain_rvalid%0d", i), rvalid0, 1);
      chk($sformatf("drain_rdata%0d", i), rdata0, i);
      chk($sformatf("drain_count%0d", i), count0, 16 - i);
      chk($sformatf("drain_ae%0d", i), ae0, (16 - i) <= 2);
      chk($sformatf("drain_empty%0d", i), empty0, i == 16);
      if (i < 16) chk($sformatf("fw_next%0d", i), rdata1, i + 1);
    end
    rd_en = 1'b0;
    tick();
    chk("drain_done_rvalid", rvalid0, 0);
    chk("drain_done_error", error0, 0);
    wr_en = 1'b1;
    rd_en = 1'b1;
    wdata = 8'h33;
    tick();
    chk("both_empty_count", count0, 1);
    chk("both_empty_error", error0, 1);
    chk("both_empty_unf", unf0, 1);
    chk("both_empty_rvalid", rvalid0, 0);
    wr_en = 1'b0;
    clr_err = 1'b1;
    tick();
    chk("both_empty_rdata", rdata0, 8'h33);
    chk("both_empty_unf_clr", unf0, 0);
    chk("both_empty_count0", count0, 0);
    rd_en = 1'b0;
    clr_err = 1'b0;
    wr_en = 1'b1;
    for (int k = 0; k < 8; k++) begin
      wdata = 8'(8'h80 + k);
      tick();
    end
    chk("prefill_count", count0, 8);
    rd_en = 1'b1;
    for (int c = 0; c < 40; c++) begin
      wdata = 8'(8'h88 + c);
      tick();
      chk($sformatf("conc_count%0d", c), count0, 8);
      chk($sformatf("conc_error%0d", c), error0, 0);
      chk($sformatf("conc_rdata%0d", c), {rvalid0, rdata0}, {1'b1, 8'(8'h80 + c)});
    end
    rd_en = 1'b0;
    wdata = 8'hEE;
    tick();
    chk("pre_rst_count", count0, 9);
    chk("pre_rst_fw_rvalid", rvalid1, 1);
    wr_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_count", count0, 0);
    chk("mid_rst_empty", empty0, 1);
    chk("mid_rst_rvalid", rvalid0, 0);
    chk("mid_rst_fw_rvalid", rvalid1, 0);
    chk("mid_rst_error", error0, 0);
    chk("mid_rst_sticky", {ovf0, unf0}, 0);
    @(negedge clk);
    rst = 1'b0;
    wr_en = 1'b1;
    wdata = 8'h77;
    tick();
    chk("post_rst_count", count0, 1);
    chk("post_rst_fw_rdata", rdata1, 8'h77);
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    chk("post_rst_rdata", {rvalid0, rdata0}, {1'b1, 8'h77});
    chk("post_rst_empty", empty0, 1);
    rd_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
